vending_ctrl: RTL and testbench

Parametrised, clocked vending controller and successor to the combinational 4-to-2 selection encoder. It priority-encodes an N-line selection bus internally and accumulates coin credit. It checks stock and price, issues a one-cycle vend strobe, returns change as unit pulses, and refunds on cancel or inactivity timeout. It sits between the coin acceptor/keypad front end and the dispense/change actuators.

---
 rtl/vending_pkg.sv | 24 ++
 rtl/prio_enc.sv | 21 ++
 rtl/vending_ctrl.sv | 135 +++++++++++++
 tb/tb_vending_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and elaboration-time helpers for the vending controller.
// Pure declarations; no logic, no latency.
package vending_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int credit_w(input int max_credit);
    return $clog2(max_credit + 1);
  endfunction

  function automatic int price(input int base, input int step, input int i);
    return base + i * step;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Highest-index-wins priority encoder; combinational, zero latency, no backpressure.
// vld is low and idx is 0 when no request line is set.
module prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

  assign vld = |req;

endmodule

// File: rtl/vending_ctrl.sv
// Coin-credit vending FSM: selection vends next cycle, change paid one unit per cycle.
// Inputs are not backpressured; coins arriving while busy are returned via coin_reject.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int COIN_W     = 4,
  parameter int MAX_CREDIT = 63,
  parameter int BASE_PRICE = 10,
  parameter int PRICE_STEP = 5,
  parameter int TIMEOUT    = 1000,
  localparam int IDX_W     = idx_w(N_ITEMS),
  localparam int CREDIT_W  = credit_w(MAX_CREDIT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_val,
  input  logic [N_ITEMS-1:0]  sel_req,
  input  logic [N_ITEMS-1:0]  stock,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [IDX_W-1:0]    vend_item,
  output logic                change_pulse,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                err_soldout,
  output logic                err_funds
);

  localparam int SUM_W = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  if (price(BASE_PRICE, PRICE_STEP, N_ITEMS - 1) > MAX_CREDIT ||
      price(BASE_PRICE, PRICE_STEP, 0) > MAX_CREDIT) begin : g_bad_price
    $error("vending_ctrl: an item price exceeds MAX_CREDIT");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("vending_ctrl: TIMEOUT must be at least 1");
  end

  state_t              state, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [TMO_W-1:0]    tmo_cnt, tmo_d;
  logic [IDX_W-1:0]    item_d;
  logic                rej_d, sold_d, funds_d;

  logic [IDX_W-1:0]    sel_idx;
  logic                sel_vld;
  logic [CREDIT_W-1:0] price_sel;
  logic [SUM_W-1:0]    sum;
  logic                coin_ok, sel_ok, collect;

  prio_enc #(.N(N_ITEMS), .IDX_W(IDX_W)) u_prio_enc (
    .req (sel_req),
    .idx (sel_idx),
    .vld (sel_vld)
  );

  assign price_sel = CREDIT_W'(price(BASE_PRICE, PRICE_STEP, int'(sel_idx)));
  assign sum       = SUM_W'(credit) + SUM_W'(coin_val);
  assign coin_ok   = coin_valid && (coin_val != '0) && (sum <= SUM_W'(MAX_CREDIT));
  assign sel_ok    = sel_vld && stock[sel_idx] && (credit >= price_sel);
  assign collect   = (state == S_COLLECT);

  always_comb begin
    state_d  = state;
    credit_d = credit;
    item_d   = vend_item;
    tmo_d    = '0;
    rej_d    = 1'b0;
    sold_d   = 1'b0;
    funds_d  = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (collect && !coin_ok && !sel_vld) tmo_d = tmo_cnt + TMO_W'(1);
        if (collect && cancel) begin
          state_d = S_CHANGE;
          rej_d   = coin_valid;
        end else if (sel_ok) begin
          credit_d = credit - price_sel;
          item_d   = sel_idx;
          state_d  = S_VEND;
          rej_d    = coin_valid;
        end else begin
          // A failed selection still lets a coin in the same cycle be credited.
          sold_d  = sel_vld && !stock[sel_idx];
          funds_d = sel_vld && stock[sel_idx];
          if (coin_ok) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = S_COLLECT;
          end else begin
            rej_d = coin_valid;
            if (collect && !sel_vld && tmo_cnt == TMO_W'(TIMEOUT - 1)) state_d = S_CHANGE;
          end
        end
      end
      S_VEND: begin
        rej_d   = coin_valid;
        state_d = (credit != '0) ? S_CHANGE : S_IDLE;
      end
      default: begin
        rej_d = coin_valid;
        if (credit != '0) credit_d = credit - CREDIT_W'(1);
        if (credit <= CREDIT_W'(1)) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      credit      <= '0;
      tmo_cnt     <= '0;
      vend_item   <= '0;
      coin_reject <= 1'b0;
      err_soldout <= 1'b0;
      err_funds   <= 1'b0;
    end else begin
      state       <= state_d;
      credit      <= credit_d;
      tmo_cnt     <= tmo_d;
      vend_item   <= item_d;
      coin_reject <= rej_d;
      err_soldout <= sold_d;
      err_funds   <= funds_d;
    end
  end

  assign vend_valid   = (state == S_VEND);
  assign change_pulse = (state == S_CHANGE);
  assign busy         = (state == S_VEND) || (state == S_CHANGE);

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl (TIMEOUT shortened to 8); inputs driven 1ns after
// the rising edge and outputs sampled there, so each tick shows the result of one edge.
module tb_vending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_val = '0;
  logic [3:0] sel_req = '0;
  logic [3:0] stock = 4'b1111;
  logic       cancel = 1'b0;
  logic       vend_valid;
  logic [1:0] vend_item;
  logic       change_pulse;
  logic [5:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       err_soldout;
  logic       err_funds;

  int checks = 0;
  int failures = 0;
  int pulses;

  vending_ctrl #(.N_ITEMS(4), .COIN_W(4), .MAX_CREDIT(63), .BASE_PRICE(10),
                 .PRICE_STEP(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_req(sel_req), .stock(stock), .cancel(cancel), .vend_valid(vend_valid),
    .vend_item(vend_item), .change_pulse(change_pulse), .credit(credit), .busy(busy),
    .coin_reject(coin_reject), .err_soldout(err_soldout), .err_funds(err_funds)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [3:0] v);
    coin_valid = 1'b1; coin_val = v;
    tick();
    coin_valid = 1'b0; coin_val = '0;
  endtask

  task automatic select(input logic [3:0] s);
    sel_req = s;
    tick();
    sel_req = '0;
  endtask

  // Count change pulses until the controller leaves the busy window (bounded).
  task automatic drain(output int n);
    int guard;
    n = 0; guard = 0;
    while (busy && guard < 200) begin
      if (change_pulse) n++;
      tick();
      guard++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++; if (credit !== 6'd0) begin failures++; $display("FAIL reset_credit: got %0d expected 0", credit); end
    checks++; if ({vend_valid, change_pulse, busy, coin_reject, err_soldout, err_funds} !== 6'b0) begin failures++; $display("FAIL reset_outputs: got %b expected 000000", {vend_valid, change_pulse, busy, coin_reject, err_soldout, err_funds}); end
    rst = 1'b0; tick();
  endtask

  task automatic test_exact_credit();
    coin(4'd5);
    checks++; if (credit !== 6'd5 || coin_reject !== 1'b0) begin failures++; $display("FAIL exact_coin1: got credit %0d rej %b expected 5 0", credit, coin_reject); end
    coin(4'd5);
    checks++; if (credit !== 6'd10) begin failures++; $display("FAIL exact_coin2: got %0d expected 10", credit); end
    select(4'b0001);
    checks++; if (vend_valid !== 1'b1 || vend_item !== 2'd0 || credit !== 6'd0) begin failures++; $display("FAIL exact_vend: got v%b item %0d credit %0d expected v1 item 0 credit 0", vend_valid, vend_item, credit); end
    tick();
    checks++; if (busy !== 1'b0 || change_pulse !== 1'b0 || vend_valid !== 1'b0) begin failures++; $display("FAIL exact_idle: got busy %b chg %b vend %b expected 0 0 0", busy, change_pulse, vend_valid); end
  endtask

  task automatic test_change();
    coin(4'd10); coin(4'd10); coin(4'd10);
    checks++; if (credit !== 6'd30) begin failures++; $display("FAIL chg_credit30: got %0d expected 30", credit); end
    select(4'b0111);
    checks++; if (vend_valid !== 1'b1 || vend_item !== 2'd2 || credit !== 6'd10 || change_pulse !== 1'b0) begin failures++; $display("FAIL chg_vend2: got v%b item %0d credit %0d chg %b expected v1 item 2 credit 10 chg 0", vend_valid, vend_item, credit, change_pulse); end
    drain(pulses);
    checks++; if (pulses !== 10 || busy !== 1'b0 || credit !== 6'd0) begin failures++; $display("FAIL chg_pulses10: got %0d pulses busy %b credit %0d expected 10 0 0", pulses, busy, credit); end
    coin(4'd10); coin(4'd10); coin(4'd5);
    select(4'b1111);
    checks++; if (vend_valid !== 1'b1 || vend_item !== 2'd3 || credit !== 6'd0) begin failures++; $display("FAIL chg_vend3: got v%b item %0d credit %0d expected v1 item 3 credit 0", vend_valid, vend_item, credit); end
    tick();
    checks++; if (busy !== 1'b0 || change_pulse !== 1'b0) begin failures++; $display("FAIL chg_nochange: got busy %b chg %b expected 0 0", busy, change_pulse); end
  endtask

  task automatic test_errors();
    coin(4'd10); coin(4'd2);
    select(4'b1000);
    checks++; if (err_funds !== 1'b1 || err_soldout !== 1'b0 || credit !== 6'd12 || vend_valid !== 1'b0) begin failures++; $display("FAIL err_funds: got funds %b sold %b credit %0d vend %b expected 1 0 12 0", err_funds, err_soldout, credit, vend_valid); end
    tick();
    checks++; if (err_funds !== 1'b0) begin failures++; $display("FAIL err_funds_pulse: got %b expected 0", err_funds); end
    stock = 4'b1011;
    select(4'b0100);
    checks++; if (err_soldout !== 1'b1 || err_funds !== 1'b0 || credit !== 6'd12) begin failures++; $display("FAIL err_soldout: got sold %b funds %b credit %0d expected 1 0 12", err_soldout, err_funds, credit); end
    stock = 4'b1111;
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++; if (change_pulse !== 1'b1 || credit !== 6'd12) begin failures++; $display("FAIL err_cancel_start: got chg %b credit %0d expected 1 12", change_pulse, credit); end
    drain(pulses);
    checks++; if (pulses !== 12 || busy !== 1'b0 || credit !== 6'd0) begin failures++; $display("FAIL err_cancel_pulses: got %0d busy %b credit %0d expected 12 0 0", pulses, busy, credit); end
  endtask

  task automatic test_overflow();
    coin(4'd15); coin(4'd15); coin(4'd15); coin(4'd15);
    checks++; if (credit !== 6'd60) begin failures++; $display("FAIL ovf_credit60: got %0d expected 60", credit); end
    coin(4'd5);
    checks++; if (coin_reject !== 1'b1 || credit !== 6'd60) begin failures++; $display("FAIL ovf_reject: got rej %b credit %0d expected 1 60", coin_reject, credit); end
    coin(4'd3);
    checks++; if (coin_reject !== 1'b0 || credit !== 6'd63) begin failures++; $display("FAIL ovf_accept3: got rej %b credit %0d expected 0 63", coin_reject, credit); end
    coin(4'd0);
    checks++; if (coin_reject !== 1'b1 || credit !== 6'd63) begin failures++; $display("FAIL zero_coin: got rej %b credit %0d expected 1 63", coin_reject, credit); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    drain(pulses);
    checks++; if (pulses !== 63 || credit !== 6'd0) begin failures++; $display("FAIL ovf_refund: got %0d pulses credit %0d expected 63 0", pulses, credit); end
  endtask

  task automatic test_simultaneous();
    coin(4'd10); coin(4'd10);
    coin_valid = 1'b1; coin_val = 4'd5; sel_req = 4'b0001;
    tick();
    coin_valid = 1'b0; coin_val = '0; sel_req = '0;
    checks++; if (vend_valid !== 1'b1 || vend_item !== 2'd0 || coin_reject !== 1'b1 || credit !== 6'd10) begin failures++; $display("FAIL sim_coin_sel: got v%b item %0d rej %b credit %0d expected v1 item 0 rej 1 credit 10", vend_valid, vend_item, coin_reject, credit); end
    drain(pulses);
    checks++; if (pulses !== 10) begin failures++; $display("FAIL sim_change: got %0d expected 10", pulses); end
    coin(4'd5); coin(4'd2);
    for (int i = 0; i < 7; i++) tick();
    checks++; if (busy !== 1'b0 || credit !== 6'd7) begin failures++; $display("FAIL tmo_early: got busy %b credit %0d expected 0 7", busy, credit); end
    tick();
    checks++; if (change_pulse !== 1'b1 || credit !== 6'd7) begin failures++; $display("FAIL tmo_fire: got chg %b credit %0d expected 1 7", change_pulse, credit); end
    drain(pulses);
    checks++; if (pulses !== 7 || busy !== 1'b0) begin failures++; $display("FAIL tmo_refund: got %0d busy %b expected 7 0", pulses, busy); end
    coin(4'd10);
    coin_valid = 1'b1; coin_val = 4'd5; sel_req = 4'b1000;
    tick();
    coin_valid = 1'b0; coin_val = '0; sel_req = '0;
    checks++; if (err_funds !== 1'b1 || coin_reject !== 1'b0 || credit !== 6'd15) begin failures++; $display("FAIL failsel_coin: got funds %b rej %b credit %0d expected 1 0 15", err_funds, coin_reject, credit); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    drain(pulses);
    checks++; if (pulses !== 15) begin failures++; $display("FAIL failsel_refund: got %0d expected 15", pulses); end
  endtask

  task automatic test_reset_busy();
    coin(4'd10); coin(4'd10); coin(4'd5);
    select(4'b0001);
    checks++; if (vend_valid !== 1'b1 || credit !== 6'd15) begin failures++; $display("FAIL rb_vend: got v%b credit %0d expected v1 credit 15", vend_valid, credit); end
    coin_valid = 1'b1; coin_val = 4'd5;
    tick();
    coin_valid = 1'b0; coin_val = '0;
    checks++; if (coin_reject !== 1'b1 || credit !== 6'd15 || change_pulse !== 1'b1) begin failures++; $display("FAIL rb_coin_in_vend: got rej %b credit %0d chg %b expected 1 15 1", coin_reject, credit, change_pulse); end
    sel_req = 4'b1000; cancel = 1'b1;
    tick();
    sel_req = '0; cancel = 1'b0;
    checks++; if (err_funds !== 1'b0 || err_soldout !== 1'b0 || busy !== 1'b1 || credit !== 6'd14) begin failures++; $display("FAIL rb_ignore: got funds %b sold %b busy %b credit %0d expected 0 0 1 14", err_funds, err_soldout, busy, credit); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (credit !== 6'd0 || change_pulse !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rb_reset: got credit %0d chg %b busy %b expected 0 0 0", credit, change_pulse, busy); end
    tick();
    checks++; if (change_pulse !== 1'b0 || credit !== 6'd0) begin failures++; $display("FAIL rb_after: got chg %b credit %0d expected 0 0", change_pulse, credit); end
  endtask

  initial begin
    test_reset();
    test_exact_credit();
    test_change();
    test_errors();
    test_overflow();
    test_simultaneous();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
